// File: rtl/alu_writeback.sv
// Registered writeback stage behind the alu: architectural flag register, in-order
// register-file write buffer with valid/ready drain, and a forwarding lookup over pending writes.
module alu_writeback #(
  parameter int DEPTH = 2,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_c,
  input  logic          in_carry,
  input  logic          in_zero,
  input  logic          in_neg,
  input  logic [AW-1:0] in_dest,
  input  logic          in_wr_reg,
  input  logic          in_wr_flags,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [AW-1:0] wb_dest,
  output logic [DW-1:0] wb_data,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_n,
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [AW-1:0] dest_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // in_ready depends only on registered count, so wb_ready never reaches it.
  assign in_ready = (count != FULL_COUNT);
  assign wb_valid = (count != '0);
  assign accept   = in_valid & in_ready & ~flush;
  assign push     = accept & in_wr_reg;
  assign pop      = wb_valid & wb_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flags are never rolled back by flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (accept && in_wr_flags) begin
      flag_c <= in_carry;
      flag_z <= in_zero;
      flag_n <= in_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= in_dest;
      data_mem[wr_ptr] <= in_c;
    end
  end

  // Storage is not reset; outputs are gated by occupancy so empty reads as zero.
  assign wb_dest = wb_valid ? dest_mem[rd_ptr] : '0;
  assign wb_data = wb_valid ? data_mem[rd_ptr] : '0;

  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    // Walk oldest to youngest so the last match (closest to tail) wins.
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (dest_mem[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: vector table with expected flags/occupancy,
// plus a queue scoreboard of buffered writes for drain order, data and forwarding.
module tb_alu_writeback;

  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_c = '0;
  logic          in_carry = 1'b0;
  logic          in_zero = 1'b0;
  logic          in_neg = 1'b0;
  logic [AW-1:0] in_dest = '0;
  logic          in_wr_reg = 1'b0;
  logic          in_wr_flags = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          flag_c;
  logic          flag_z;
  logic          flag_n;
  logic [AW-1:0] fwd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  alu_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
    .in_carry(in_carry), .in_zero(in_zero), .in_neg(in_neg),
    .in_dest(in_dest), .in_wr_reg(in_wr_reg), .in_wr_flags(in_wr_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] c;
    logic          cy, z, n;
    logic [AW-1:0] d;
    logic          wr, wf, rdy, fl;
    logic [AW-1:0] fa;
    logic [2:0]    ef;   // expected {c,z,n} after the edge
    logic          ewv;  // expected wb_valid after the edge
  } vec_t;

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  vec_t vecs[22];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] c, input logic cy, input logic z,
                              input logic n, input logic [AW-1:0] d, input logic wr, input logic wf,
                              input logic rdy, input logic fl, input logic [AW-1:0] fa,
                              input logic [2:0] ef, input logic ewv);
    vec_t t;
    t.v = v; t.c = c; t.cy = cy; t.z = z; t.n = n; t.d = d; t.wr = wr; t.wf = wf;
    t.rdy = rdy; t.fl = fl; t.fa = fa; t.ef = ef; t.ewv = ewv;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input vec_t v, input string tag);
    logic          exp_rdy, acc, pop, ehit;
    logic [DW-1:0] edata;
    in_valid = v.v; in_c = v.c; in_carry = v.cy; in_zero = v.z; in_neg = v.n;
    in_dest = v.d; in_wr_reg = v.wr; in_wr_flags = v.wf; wb_ready = v.rdy;
    flush = v.fl; fwd_addr = v.fa;
    #1;
    exp_rdy = (sb.size() != DEPTH);
    chk({tag, " in_ready"}, DW'(in_ready), DW'(exp_rdy));
    chk({tag, " wb_valid_pre"}, DW'(wb_valid), DW'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, " wb_dest"}, DW'(wb_dest), DW'(sb[0].dest));
      chk({tag, " wb_data"}, wb_data, sb[0].data);
    end
    ehit = 1'b0; edata = '0;
    foreach (sb[i]) if (sb[i].dest == v.fa) begin ehit = 1'b1; edata = sb[i].data; end
    chk({tag, " fwd_hit"}, DW'(fwd_hit), DW'(ehit));
    chk({tag, " fwd_data"}, fwd_data, edata);
    acc = v.v && exp_rdy && !v.fl;
    pop = (sb.size() != 0) && v.rdy;
    if (v.fl) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (acc && v.wr) sb.push_back('{v.d, v.c});
    end
    @(posedge clk); #1;
    chk({tag, " flags"}, DW'({flag_c, flag_z, flag_n}), DW'(v.ef));
    chk({tag, " wb_valid_post"}, DW'(wb_valid), DW'(v.ewv));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " wb_valid"}, DW'(wb_valid), 0);
    chk({tag, " in_ready"}, DW'(in_ready), 1);
    chk({tag, " flags"}, DW'({flag_c, flag_z, flag_n}), 0);
    chk({tag, " fwd_hit"}, DW'(fwd_hit), 0);
    chk({tag, " wb_dest"}, DW'(wb_dest), 0);
    chk({tag, " wb_data"}, wb_data, 0);
  endtask

  initial begin
    //               v   c             cy z  n  d  wr wf rdy fl fa  ef      ewv
    vecs[0]  = mk(1, 32'h0000_0005, 0, 0, 0, 3, 1, 1, 1, 0, 0, 3'b000, 1);
    vecs[1]  = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0);
    vecs[2]  = mk(1, 32'h1,         1, 0, 0, 4, 1, 1, 1, 0, 0, 3'b100, 1);
    vecs[3]  = mk(1, 32'h2,         0, 1, 1, 5, 1, 0, 1, 0, 0, 3'b100, 1);
    vecs[4]  = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b100, 0);
    vecs[5]  = mk(1, 32'hAAAA_0001, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'b100, 1);
    vecs[6]  = mk(1, 32'hBBBB_0002, 0, 0, 0, 2, 1, 0, 0, 0, 0, 3'b100, 1);
    vecs[7]  = mk(1, 32'hCCCC_0003, 0, 0, 0, 8, 1, 0, 0, 0, 1, 3'b100, 1);
    vecs[8]  = mk(1, 32'hCCCC_0003, 0, 0, 0, 8, 1, 0, 1, 0, 1, 3'b100, 1);
    vecs[9]  = mk(1, 32'hCCCC_0003, 0, 0, 0, 8, 1, 0, 0, 0, 2, 3'b100, 1);
    vecs[10] = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 0, 8, 3'b100, 1);
    vecs[11] = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 0, 8, 3'b100, 0);
    vecs[12] = mk(1, 32'h11,        0, 0, 0, 7, 1, 0, 0, 0, 7, 3'b100, 1);
    vecs[13] = mk(1, 32'h22,        0, 0, 0, 7, 1, 0, 0, 0, 7, 3'b100, 1);
    vecs[14] = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0, 7, 3'b100, 1);
    vecs[15] = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0, 6, 3'b100, 1);
    vecs[16] = mk(1, 32'h33,        0, 1, 1, 9, 1, 1, 0, 1, 7, 3'b100, 0);
    vecs[17] = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 1, 1, 7, 3'b100, 0);
    vecs[18] = mk(1, 32'h0,         0, 1, 0, 2, 0, 1, 1, 0, 2, 3'b010, 0);
    vecs[19] = mk(1, 32'h8000_0000, 1, 0, 1, 3, 1, 1, 0, 0, 3, 3'b101, 1);
    vecs[20] = mk(1, 32'h44,        0, 0, 0, 6, 1, 0, 0, 0, 3, 3'b101, 1);
    vecs[21] = mk(0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0, 6, 3'b101, 1);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_held");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("reset_released");

    for (int i = 0; i < 22; i++) tick(vecs[i], $sformatf("v%0d", i));

    // Async reset mid-stream with two entries buffered: outputs clear before the next edge.
    in_valid = 1'b0; wb_ready = 1'b0; fwd_addr = 4'd6;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    sb.delete();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("after_async_reset");

    tick(mk(1, 32'h77, 1, 0, 0, 5, 1, 1, 1, 0, 5, 3'b100, 1), "post_rst_push");
    tick(mk(0, 32'h0,  0, 0, 0, 0, 0, 0, 1, 0, 5, 3'b100, 0), "post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
